// File: rtl/csr_access_pkg.sv
// Shared encodings for the machine-mode CSR access sequencer: op codes, FSM states,
// requester IDs and the read-only address field.
package csr_access_pkg;

    typedef enum logic [1:0] {
        OP_READ = 2'b00,
        OP_RW   = 2'b01,
        OP_SET  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WAIT = 2'b10,
        ST_WB   = 2'b11
    } state_e;

    localparam logic PORT_EX = 1'b0;
    localparam logic PORT_TR = 1'b1;

    // Address bits [11:10] equal to this value mark a read-only CSR.
    localparam logic [1:0] RO_FIELD = 2'b11;

    function automatic logic is_read_only(input logic [1:0] addr_field);
        return addr_field == RO_FIELD;
    endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational read-modify-write step: derives the new CSR value, whether it is
// written back, and whether the access is an illegal write to a read-only CSR.
module csr_rmw_alu
    import csr_access_pkg::*;
(
    input  op_e         op,
    input  logic [31:0] old_val,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] new_val,
    output logic        wr_en,
    output logic        err
);

    logic       suppress;
    logic       read_only;
    logic [9:0] addr_unused;

    assign addr_unused = addr[9:0];
    assign read_only   = is_read_only(addr[11:10]);

    // Set/clear with an all-zero mask behave as pure reads, so they never fault.
    always_comb begin
        suppress = 1'b0;
        new_val  = old_val;
        case (op)
            OP_READ: suppress = 1'b1;
            OP_RW:   new_val  = wdata;
            OP_SET: begin
                new_val  = old_val | wdata;
                suppress = (wdata == '0);
            end
            OP_CLR: begin
                new_val  = old_val & ~wdata;
                suppress = (wdata == '0);
            end
            default: suppress = 1'b1;
        endcase
    end

    assign wr_en = !suppress && !read_only;
    assign err   = !suppress && read_only;

endmodule

// File: rtl/csr_access_ctrl.sv
// Arbitrates the exec and trap requesters onto the single csrs_machine port and runs
// each request as an atomic read-modify-write. Optional macro: CSR_ACCESS_TIMEOUT_EN.
module csr_access_ctrl
    import csr_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        EX_REQ,
    input  logic [1:0]  EX_OP,
    input  logic [11:0] EX_ADDR,
    input  logic [31:0] EX_WDATA,
    output logic        EX_ACK,
    output logic [31:0] EX_RDATA,
    output logic        EX_ERR,

    input  logic        TR_REQ,
    input  logic [1:0]  TR_OP,
    input  logic [11:0] TR_ADDR,
    input  logic [31:0] TR_WDATA,
    output logic        TR_ACK,
    output logic [31:0] TR_RDATA,
    output logic        TR_ERR,

    output logic        CSR_RDEN,
    output logic [11:0] CSR_RADDR,
    input  logic        CSR_RVALID,
    input  logic [31:0] CSR_RDATA,
    output logic        CSR_WREN,
    output logic [11:0] CSR_WADDR,
    output logic [31:0] CSR_WDATA
);

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;
    op_e         op_q, op_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        rden_d;
    logic [11:0] raddr_d;
    logic        wren_d;
    logic [11:0] waddr_d;
    logic [31:0] cwdata_d;
    logic        ack_d;
    logic [31:0] rdata_d;
    logic        err_d;

    logic [31:0] alu_new;
    logic        alu_we;
    logic        alu_err;
    logic        timed_out;

    csr_rmw_alu u_alu (
        .op      (op_q),
        .old_val (CSR_RDATA),
        .wdata   (wdata_q),
        .addr    (addr_q),
        .new_val (alu_new),
        .wr_en   (alu_we),
        .err     (alu_err)
    );

`ifdef CSR_ACCESS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q;

    // Counts WAIT cycles; the final silent cycle forces the abort path.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_q <= '0;
        end
    end

    assign timed_out = (state_q == ST_WAIT) && !CSR_RVALID &&
                       (wait_cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic [31:0] timeout_unused;

    assign timeout_unused = 32'(TIMEOUT);
    assign timed_out      = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rden_d   = 1'b0;
        raddr_d  = '0;
        wren_d   = 1'b0;
        waddr_d  = '0;
        cwdata_d = '0;
        ack_d    = 1'b0;
        rdata_d  = '0;
        err_d    = 1'b0;

        case (state_q)
            // Trap has fixed priority; once granted a request runs to completion.
            ST_IDLE: begin
                if (TR_REQ || EX_REQ) begin
                    gnt_d   = TR_REQ ? PORT_TR : PORT_EX;
                    op_d    = op_e'(TR_REQ ? TR_OP : EX_OP);
                    addr_d  = TR_REQ ? TR_ADDR : EX_ADDR;
                    wdata_d = TR_REQ ? TR_WDATA : EX_WDATA;
                    rden_d  = 1'b1;
                    raddr_d = addr_d;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (CSR_RVALID) begin
                    wren_d   = alu_we;
                    waddr_d  = alu_we ? addr_q : '0;
                    cwdata_d = alu_we ? alu_new : '0;
                    ack_d    = 1'b1;
                    rdata_d  = CSR_RDATA;
                    err_d    = alu_err;
                    state_d  = ST_WB;
                end else if (timed_out) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Every output is registered so the write pulse and ACK land in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            gnt_q     <= PORT_EX;
            op_q      <= OP_READ;
            addr_q    <= '0;
            wdata_q   <= '0;
            CSR_RDEN  <= 1'b0;
            CSR_RADDR <= '0;
            CSR_WREN  <= 1'b0;
            CSR_WADDR <= '0;
            CSR_WDATA <= '0;
            EX_ACK    <= 1'b0;
            EX_RDATA  <= '0;
            EX_ERR    <= 1'b0;
            TR_ACK    <= 1'b0;
            TR_RDATA  <= '0;
            TR_ERR    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            CSR_RDEN  <= rden_d;
            CSR_RADDR <= raddr_d;
            CSR_WREN  <= wren_d;
            CSR_WADDR <= waddr_d;
            CSR_WDATA <= cwdata_d;
            EX_ACK    <= ack_d && (gnt_q == PORT_EX);
            EX_RDATA  <= (gnt_q == PORT_EX) ? rdata_d : '0;
            EX_ERR    <= err_d && (gnt_q == PORT_EX);
            TR_ACK    <= ack_d && (gnt_q == PORT_TR);
            TR_RDATA  <= (gnt_q == PORT_TR) ? rdata_d : '0;
            TR_ERR    <= err_d && (gnt_q == PORT_TR);
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: the bench plays csrs_machine from a
// reference CSR image and checks every request against a spec-level model.
module tb_csr_access_ctrl;

    localparam int TIMEOUT_CYC = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EX_REQ;
    logic [1:0]  EX_OP;
    logic [11:0] EX_ADDR;
    logic [31:0] EX_WDATA;
    logic        EX_ACK;
    logic [31:0] EX_RDATA;
    logic        EX_ERR;
    logic        TR_REQ;
    logic [1:0]  TR_OP;
    logic [11:0] TR_ADDR;
    logic [31:0] TR_WDATA;
    logic        TR_ACK;
    logic [31:0] TR_RDATA;
    logic        TR_ERR;
    logic        CSR_RDEN;
    logic [11:0] CSR_RADDR;
    logic        CSR_RVALID;
    logic [31:0] CSR_RDATA;
    logic        CSR_WREN;
    logic [11:0] CSR_WADDR;
    logic [31:0] CSR_WDATA;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] refMem [0:4095];
    int          rvalidDelay;
    bit          respEnable;
    bit          pending;
    int          pendCnt;
    logic [11:0] pendAddr;

    csr_access_ctrl #(.TIMEOUT(TIMEOUT_CYC)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EX_REQ     (EX_REQ),
        .EX_OP      (EX_OP),
        .EX_ADDR    (EX_ADDR),
        .EX_WDATA   (EX_WDATA),
        .EX_ACK     (EX_ACK),
        .EX_RDATA   (EX_RDATA),
        .EX_ERR     (EX_ERR),
        .TR_REQ     (TR_REQ),
        .TR_OP      (TR_OP),
        .TR_ADDR    (TR_ADDR),
        .TR_WDATA   (TR_WDATA),
        .TR_ACK     (TR_ACK),
        .TR_RDATA   (TR_RDATA),
        .TR_ERR     (TR_ERR),
        .CSR_RDEN   (CSR_RDEN),
        .CSR_RADDR  (CSR_RADDR),
        .CSR_RVALID (CSR_RVALID),
        .CSR_RDATA  (CSR_RDATA),
        .CSR_WREN   (CSR_WREN),
        .CSR_WADDR  (CSR_WADDR),
        .CSR_WDATA  (CSR_WDATA)
    );

    always #5 CLK = ~CLK;

    wire [125:0] allOuts = {EX_ACK, EX_RDATA, EX_ERR, TR_ACK, TR_RDATA, TR_ERR,
                            CSR_RDEN, CSR_RADDR, CSR_WREN, CSR_WADDR, CSR_WDATA};

    // csrs_machine stand-in: answers RDEN with the reference image, optionally late or never.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            CSR_RVALID <= 1'b0;
            CSR_RDATA  <= '0;
            pending    <= 1'b0;
            pendCnt    <= 0;
            pendAddr   <= '0;
        end else begin
            CSR_RVALID <= 1'b0;
            CSR_RDATA  <= '0;
            if (CSR_RDEN && respEnable) begin
                if (rvalidDelay == 0) begin
                    CSR_RVALID <= 1'b1;
                    CSR_RDATA  <= refMem[CSR_RADDR];
                end else begin
                    pending  <= 1'b1;
                    pendCnt  <= rvalidDelay;
                    pendAddr <= CSR_RADDR;
                end
            end else if (pending) begin
                if (pendCnt == 1) begin
                    CSR_RVALID <= 1'b1;
                    CSR_RDATA  <= refMem[pendAddr];
                    pending    <= 1'b0;
                end
                pendCnt <= pendCnt - 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit isTr, input bit req, input logic [1:0] op,
                                 input logic [11:0] addr, input logic [31:0] wd);
        if (isTr) begin
            TR_REQ = req; TR_OP = op; TR_ADDR = addr; TR_WDATA = wd;
        end else begin
            EX_REQ = req; EX_OP = op; EX_ADDR = addr; EX_WDATA = wd;
        end
    endtask

    // RISC-V csrrw/csrrs/csrrc semantics; CSRs at 0xC00 and above are read-only.
    function automatic void predict(input logic [1:0] op, input logic [11:0] addr,
                                    input logic [31:0] wd, input logic [31:0] oldV,
                                    output logic [31:0] newV, output bit wr, output bit err);
        bit changes;
        bit ro;
        changes = (op == 2'b01) || (op != 2'b00 && wd != 32'd0);
        ro      = (addr >= 12'hC00);
        newV    = (op == 2'b01) ? wd : (op == 2'b10) ? (oldV | wd) : (oldV & ~wd);
        wr      = changes && !ro;
        err     = changes && ro;
    endfunction

    task automatic runTxn(input bit isTr, input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] wd, input int delay, input bit noResp);
        logic [31:0] oldV, newV, expRd, gotRd, seenWdata;
        logic [11:0] seenWaddr;
        bit          expWr, expErr, gotAck;
        logic        gotErr;
        int          expCyc, ackCyc, wrenCnt, otherAcks, cyc;

        oldV = refMem[addr];
        predict(op, addr, wd, oldV, newV, expWr, expErr);
        expRd  = oldV;
        expCyc = 3 + delay;
        if (noResp) begin
            expRd  = '0;
            expErr = 1'b1;
            expWr  = 1'b0;
            expCyc = 2 + TIMEOUT_CYC;
        end
        rvalidDelay = delay;
        respEnable  = !noResp;
        gotAck = 0; gotErr = 1'bx; gotRd = 'x; ackCyc = -1;
        wrenCnt = 0; otherAcks = 0; cyc = 0;
        seenWaddr = '0; seenWdata = '0;

        @(negedge CLK);
        applyStimulus(isTr, 1'b1, op, addr, wd);
        while (!gotAck && cyc < 60) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) begin
                checkOutput("rdenCycle1", 128'(CSR_RDEN), 128'(1));
                checkOutput("raddr", 128'(CSR_RADDR), 128'(addr));
            end
            if (cyc == 2) checkOutput("rdenOnePulse", 128'(CSR_RDEN), 128'(0));
            if (CSR_WREN) begin
                wrenCnt++;
                seenWaddr = CSR_WADDR;
                seenWdata = CSR_WDATA;
            end
            if (isTr ? EX_ACK : TR_ACK) otherAcks++;
            if (isTr ? TR_ACK : EX_ACK) begin
                gotAck = 1;
                ackCyc = cyc;
                gotRd  = isTr ? TR_RDATA : EX_RDATA;
                gotErr = isTr ? TR_ERR : EX_ERR;
            end
        end
        applyStimulus(isTr, 1'b0, 2'b00, 12'h000, 32'h0);

        checkOutput("ackSeen", 128'(gotAck), 128'(1));
        checkOutput("ackCycle", 128'(ackCyc), 128'(expCyc));
        checkOutput("rdata", 128'(gotRd), 128'(expRd));
        checkOutput("err", 128'(gotErr), 128'(expErr));
        checkOutput("wrenCount", 128'(wrenCnt), 128'(expWr ? 1 : 0));
        checkOutput("otherPortAck", 128'(otherAcks), 128'(0));
        if (expWr) begin
            checkOutput("waddr", 128'(seenWaddr), 128'(addr));
            checkOutput("wdata", 128'(seenWdata), 128'(newV));
            refMem[addr] = newV;
        end
        @(negedge CLK);
        checkOutput("ackReturnsZero", 128'({EX_ACK, EX_RDATA, EX_ERR, TR_ACK, TR_RDATA, TR_ERR}),
                    128'(0));
    endtask

    task automatic runPriority();
        logic [11:0] a;
        logic [31:0] trOld, trNew, exOld, exNew, trRd, exRd;
        logic [31:0] wrData [2];
        int          wrCyc [2];
        logic        trE, exE;
        bit          trWr, trErr, exWr, exErr;
        int          trAckCyc, exAckCyc, trAcks, exAcks, bothAcks, wrenCnt;

        a = 12'h305;
        trOld = refMem[a];
        predict(2'b10, a, 32'h0000_00F0, trOld, trNew, trWr, trErr);
        exOld = trWr ? trNew : trOld;
        predict(2'b01, a, 32'hCAFE_0000, exOld, exNew, exWr, exErr);
        rvalidDelay = 0;
        respEnable  = 1;
        trAckCyc = -1; exAckCyc = -1; trAcks = 0; exAcks = 0; bothAcks = 0; wrenCnt = 0;
        trRd = 'x; exRd = 'x; trE = 1'bx; exE = 1'bx;
        wrCyc[0] = -1; wrCyc[1] = -1; wrData[0] = '0; wrData[1] = '0;

        @(negedge CLK);
        applyStimulus(1'b1, 1'b1, 2'b10, a, 32'h0000_00F0);
        applyStimulus(1'b0, 1'b1, 2'b01, a, 32'hCAFE_0000);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge CLK);
            if (CSR_WREN) begin
                if (wrenCnt < 2) begin
                    wrCyc[wrenCnt]  = cyc;
                    wrData[wrenCnt] = CSR_WDATA;
                end
                wrenCnt++;
            end
            if (TR_ACK && EX_ACK) bothAcks++;
            if (TR_ACK) begin
                trAcks++;
                trAckCyc = cyc;
                trRd = TR_RDATA;
                trE  = TR_ERR;
                if (trWr) refMem[a] = trNew;
                applyStimulus(1'b1, 1'b0, 2'b00, 12'h000, 32'h0);
            end
            if (EX_ACK) begin
                exAcks++;
                exAckCyc = cyc;
                exRd = EX_RDATA;
                exE  = EX_ERR;
                applyStimulus(1'b0, 1'b0, 2'b00, 12'h000, 32'h0);
            end
        end
        if (exWr) refMem[a] = exNew;

        checkOutput("prioTrAckCycle", 128'(trAckCyc), 128'(3));
        checkOutput("prioExAckCycle", 128'(exAckCyc), 128'(7));
        checkOutput("prioTrAckCount", 128'(trAcks), 128'(1));
        checkOutput("prioExAckCount", 128'(exAcks), 128'(1));
        checkOutput("prioBothAck", 128'(bothAcks), 128'(0));
        checkOutput("prioTrRdata", 128'(trRd), 128'(trOld));
        checkOutput("prioExRdata", 128'(exRd), 128'(exOld));
        checkOutput("prioTrErr", 128'(trE), 128'(trErr));
        checkOutput("prioExErr", 128'(exE), 128'(exErr));
        checkOutput("prioWrenCount", 128'(wrenCnt), 128'(int'(trWr) + int'(exWr)));
        checkOutput("prioWrCycle0", 128'(wrCyc[0]), 128'(3));
        checkOutput("prioWrData0", 128'(wrData[0]), 128'(trNew));
        checkOutput("prioWrCycle1", 128'(wrCyc[1]), 128'(7));
        checkOutput("prioWrData1", 128'(wrData[1]), 128'(exNew));
    endtask

    task automatic runResetInWait();
        int events;
        events = 0;
        respEnable = 0;
        @(negedge CLK);
        applyStimulus(1'b0, 1'b1, 2'b01, 12'h342, 32'h1111_2222);
        @(negedge CLK);
        checkOutput("rstRdenBefore", 128'(CSR_RDEN), 128'(1));
        @(negedge CLK);
        #2 RST = 1'b1;
        #1 checkOutput("rstAsyncOutputsZero", 128'(allOuts), 128'(0));
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (EX_ACK || TR_ACK || CSR_WREN) events++;
            if (i == 0) applyStimulus(1'b0, 1'b0, 2'b00, 12'h000, 32'h0);
            if (i == 2) RST = 1'b0;
        end
        checkOutput("rstNoAckNoWrite", 128'(events), 128'(0));
        respEnable = 1;
        runTxn(1'b0, 2'b01, 12'h342, 32'h1111_2222, 0, 1'b0);
    endtask

    initial begin
        logic [11:0] pool [8];
        pool[0] = 12'h340; pool[1] = 12'h300; pool[2] = 12'hF14; pool[3] = 12'hC00;
        pool[4] = 12'h305; pool[5] = 12'h7FF; pool[6] = 12'hBFF; pool[7] = 12'h341;

        RST = 1'b1;
        respEnable  = 1;
        rvalidDelay = 0;
        applyStimulus(1'b0, 1'b0, 2'b00, 12'h000, 32'h0);
        applyStimulus(1'b1, 1'b0, 2'b00, 12'h000, 32'h0);
        for (int i = 0; i < 4096; i++) refMem[i] = $urandom();
        refMem[12'h340] = 32'h1234_5678;
        refMem[12'h300] = 32'h0000_0001;
        refMem[12'hF14] = 32'h0000_0A5A;

        repeat (3) @(negedge CLK);
        checkOutput("resetOutputsZero", 128'(allOuts), 128'(0));
        RST = 1'b0;
        @(negedge CLK);

        runTxn(1'b0, 2'b01, 12'h340, 32'hDEAD_BEEF, 0, 1'b0);
        runTxn(1'b0, 2'b10, 12'h300, 32'h0000_0008, 0, 1'b0);
        runTxn(1'b0, 2'b11, 12'h300, 32'h0000_0001, 0, 1'b0);
        runTxn(1'b0, 2'b10, 12'h300, 32'h0000_0000, 0, 1'b0);
        runTxn(1'b0, 2'b01, 12'hF14, 32'h5555_AAAA, 0, 1'b0);
        runTxn(1'b0, 2'b00, 12'hF14, 32'h0000_0000, 0, 1'b0);
        runTxn(1'b1, 2'b01, 12'h341, 32'h8000_0004, 0, 1'b0);
        runTxn(1'b1, 2'b11, 12'hC00, 32'h0000_0000, 2, 1'b0);

        runPriority();
        runResetInWait();

`ifdef CSR_ACCESS_TIMEOUT_EN
        runTxn(1'b0, 2'b01, 12'h343, 32'hA5A5_A5A5, 0, 1'b1);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [31:0] wd;
            wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
            runTxn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   pool[$urandom_range(0, 7)], wd, $urandom_range(0, 3), 1'b0);
        end

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
